// File: rtl/fsm_lockstep_monitor.sv
// Lockstep monitor for NUM_CH redundant copies of one FSM.
// Votes a reference state/output and latches a sticky fault with a snapshot.
module fsm_lockstep_monitor #(
    parameter int NUM_CH      = 3,
    parameter int STATE_W     = 3,
    parameter int NUM_STATES  = 5,
    parameter int OUT_W       = 1,
    parameter int RESET_STATE = 0,
    parameter int GRACE       = 2,
    parameter int ARM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clear,
    input  logic [NUM_CH*STATE_W-1:0] ch_state,
    input  logic [NUM_CH*OUT_W-1:0]   ch_out,
    output logic [STATE_W-1:0]        voted_state,
    output logic [OUT_W-1:0]          voted_out,
    output logic [2:0]                mon_state,
    output logic                      fault,
    output logic [3:0]                fault_cause,
    output logic [NUM_CH-1:0]         fault_mask,
    output logic [NUM_CH*STATE_W-1:0] fault_states,
    output logic [CNT_W-1:0]          mismatch_cnt
);

    localparam int VW     = STATE_W + OUT_W;
    localparam int ACNT_W = $clog2(ARM_TIMEOUT + 1);
    localparam int GCNT_W = $clog2(GRACE + 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_GRACE = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam logic [STATE_W-1:0] RST_CODE = STATE_W'(RESET_STATE);
    localparam logic [ACNT_W-1:0]  A_LIM    = ACNT_W'(ARM_TIMEOUT - 1);
    localparam logic [ACNT_W-1:0]  A_MAX    = ACNT_W'(ARM_TIMEOUT);
    localparam logic [GCNT_W-1:0]  G_LIM    = GCNT_W'(GRACE);

    logic [VW-1:0]             word [NUM_CH];
    logic [VW-1:0]             vote;
    logic [NUM_CH-1:0]         mask;
    logic [NUM_CH-1:0]         changed;
    logic [NUM_CH*STATE_W-1:0] prev_state;
    logic                      illegal_raw;
    logic                      all_reset;
    logic                      desync_raw;
    int                        ones;

    logic                      active;
    logic                      ev_mism;
    logic                      ev_desync;
    logic                      ev_illegal;
    logic                      bad;

    logic [2:0]                nstate;
    logic [GCNT_W-1:0]         gcnt;
    logic [GCNT_W-1:0]         gcnt_n;
    logic [ACNT_W-1:0]         acnt;
    logic [ACNT_W-1:0]         acnt_n;
    logic                      trig;
    logic                      timeout;
    logic                      inc;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            word[i] = {ch_state[i*STATE_W +: STATE_W], ch_out[i*OUT_W +: OUT_W]};
        end
    end

    // Per-bit majority; an even split defers to copy 0.
    always_comb begin
        vote = '0;
        ones = 0;
        for (int b = 0; b < VW; b++) begin
            ones = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                ones = ones + int'(word[i][b]);
            end
            if (2 * ones > NUM_CH) begin
                vote[b] = 1'b1;
            end else if (2 * ones == NUM_CH) begin
                vote[b] = word[0][b];
            end
        end
    end

    always_comb begin
        mask        = '0;
        changed     = '0;
        illegal_raw = 1'b0;
        all_reset   = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            mask[i]    = word[i] != vote;
            changed[i] = ch_state[i*STATE_W +: STATE_W]
                         != prev_state[i*STATE_W +: STATE_W];
            if (int'(ch_state[i*STATE_W +: STATE_W]) >= NUM_STATES) begin
                illegal_raw = 1'b1;
            end
            if (ch_state[i*STATE_W +: STATE_W] != RST_CODE) begin
                all_reset = 1'b0;
            end
        end
    end

    assign desync_raw = (|changed) && !(&changed);
    assign active     = (mon_state == S_CHECK) || (mon_state == S_GRACE);
    assign ev_mism    = active && (|mask);
    assign ev_desync  = active && desync_raw;
    assign ev_illegal = active && illegal_raw;
    assign bad        = ev_mism || ev_desync;

    // A clear pulse masks every same-cycle event, so no fault can be entered.
    always_comb begin
        nstate  = mon_state;
        gcnt_n  = gcnt;
        acnt_n  = acnt;
        trig    = 1'b0;
        timeout = 1'b0;
        inc     = 1'b0;
        unique case (mon_state)
            S_IDLE: begin
                if (en) begin
                    nstate = S_ARMED;
                    acnt_n = '0;
                end
            end
            S_ARMED: begin
                if (!en) begin
                    nstate = S_IDLE;
                end else if (all_reset && !(|mask)) begin
                    nstate = S_CHECK;
                end else if (!clear && acnt >= A_LIM) begin
                    nstate  = S_FAULT;
                    trig    = 1'b1;
                    timeout = 1'b1;
                end else if (acnt < A_MAX) begin
                    acnt_n = acnt + ACNT_W'(1);
                end
            end
            S_CHECK: begin
                if (!en) begin
                    nstate = S_IDLE;
                end else if (clear) begin
                    nstate = S_CHECK;
                end else if (ev_illegal) begin
                    nstate = S_FAULT;
                    trig   = 1'b1;
                end else if (bad) begin
                    if (GRACE == 0) begin
                        nstate = S_FAULT;
                        trig   = 1'b1;
                    end else begin
                        nstate = S_GRACE;
                        gcnt_n = GCNT_W'(1);
                        inc    = 1'b1;
                    end
                end
            end
            S_GRACE: begin
                if (!en) begin
                    nstate = S_IDLE;
                end else if (clear) begin
                    nstate = S_CHECK;
                end else if (ev_illegal) begin
                    nstate = S_FAULT;
                    trig   = 1'b1;
                end else if (bad) begin
                    if (gcnt >= G_LIM) begin
                        nstate = S_FAULT;
                        trig   = 1'b1;
                    end else begin
                        gcnt_n = gcnt + GCNT_W'(1);
                        inc    = 1'b1;
                    end
                end else begin
                    nstate = S_CHECK;
                end
            end
            S_FAULT: begin
                if (clear) begin
                    nstate = en ? S_ARMED : S_IDLE;
                    acnt_n = '0;
                end
            end
            default: begin
                nstate = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mon_state    <= S_IDLE;
            fault        <= 1'b0;
            voted_state  <= '0;
            voted_out    <= '0;
            prev_state   <= '0;
            gcnt         <= '0;
            acnt         <= '0;
            mismatch_cnt <= '0;
            fault_cause  <= '0;
            fault_mask   <= '0;
            fault_states <= '0;
        end else begin
            voted_state <= vote[VW-1:OUT_W];
            voted_out   <= vote[OUT_W-1:0];
            if (mon_state != S_IDLE) begin
                prev_state <= ch_state;
            end
            mon_state <= nstate;
            fault     <= nstate == S_FAULT;
            gcnt      <= gcnt_n;
            acnt      <= acnt_n;
            if (clear) begin
                mismatch_cnt <= '0;
                fault_cause  <= '0;
                fault_mask   <= '0;
                fault_states <= '0;
            end else begin
                if (inc && mismatch_cnt != {CNT_W{1'b1}}) begin
                    mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                end
                if (trig) begin
                    fault_cause  <= fault_cause
                                    | {timeout, ev_illegal, ev_desync, ev_mism};
                    fault_mask   <= mask;
                    fault_states <= ch_state;
                end
            end
        end
    end

endmodule
